// File: rtl/ads124x_scan_ctrl.sv
// ads124x_scan_ctrl
// Channel-scan sequencer for an ADS124x delta-sigma ADC. For each enabled
// slot it writes MUX0 (WREG 0x40 0x00 <mux>) through a byte-level SPI
// engine, pulses START, waits for DRDY (with a timeout), reads the 24-bit
// result (RDATA 0x12 + 3 dummy bytes) and emits a slot-tagged sample on an
// AXI4-Stream master.
//
// Ports:
//   aclk_i, areset_i         clock, asynchronous active-high reset
//   enable_i                 run the scan loop while high
//   chan_en_i, chan_mux_i    per-slot enable mask and MUX0 values (8b/slot)
//   cmd_*_o, cmd_ready_i     byte requests to the SPI engine
//   rsp_data_i, rsp_valid_i  bytes returned by the SPI engine
//   start_o, drdy_n_i        ADS124x START / DRDY pins
//   m_axis_*                 sample stream {slot, timeout, 3'b0, data[23:0]}
//   busy_o                   FSM not in IDLE
//   timeout_cnt_o            saturating count of DRDY timeouts
module ads124x_scan_ctrl #(
  parameter int NUM_CH  = 8,
  parameter int START_W = 4,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic                  aclk_i,
  input  logic                  areset_i,
  input  logic                  enable_i,
  input  logic [NUM_CH-1:0]     chan_en_i,
  input  logic [8*NUM_CH-1:0]   chan_mux_i,
  output logic [7:0]            cmd_data_o,
  output logic                  cmd_last_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  input  logic [7:0]            rsp_data_i,
  input  logic                  rsp_valid_i,
  output logic                  start_o,
  input  logic                  drdy_n_i,
  output logic [31:0]           m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  busy_o,
  output logic [15:0]           timeout_cnt_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = (START_W > 1) ? $clog2(START_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WREG, S_START_P, S_WAIT_DRDY, S_RDATA, S_OUT
  } state_t;

  state_t        state_q;
  logic [3:0]    slot_q, ptr_q;
  logic [7:0]    mux_q;
  logic [2:0]    byte_cnt_q, rsp_cnt_q;
  logic          cmd_valid_q, cmd_last_q;
  logic [7:0]    cmd_data_q;
  logic          start_q;
  logic [SW-1:0] start_cnt_q;
  logic [TW-1:0] wait_q;
  logic [15:0]   data_hi_q;
  logic [31:0]   tdata_q;
  logic          tvalid_q;
  logic          busy_q;
  logic [15:0]   timeout_cnt_q;
  logic          drdy_s1_q, drdy_s2_q, drdy_prev_q;

  logic [2:0]    byte_cnt_d, rsp_cnt_d, frame_len_d;
  logic [3:0]    ptr_inc_d;
  logic [4:0]    pick_idle_d, pick_next_d;
  logic          drdy_fall_d;

  // Lowest enabled slot at or after 'from', wrapping modulo NUM_CH.
  // Result is {found, slot}.
  function automatic logic [4:0] find_slot(input logic [NUM_CH-1:0] en,
                                           input logic [3:0] from);
    logic [4:0] r;
    int j;
    r = 5'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = (int'(from) + i) % NUM_CH;
      if (en[j]) r = {1'b1, j[3:0]};
    end
    return r;
  endfunction

  function automatic logic [7:0] wreg_byte(input logic [2:0] idx, input logic [7:0] mux);
    case (idx)
      3'd0:    return 8'h40;
      3'd1:    return 8'h00;
      default: return mux;
    endcase
  endfunction

  function automatic logic [7:0] rdata_byte(input logic [2:0] idx);
    return (idx == 3'd0) ? 8'h12 : 8'hFF;
  endfunction

  assign byte_cnt_d  = byte_cnt_q + {2'b00, cmd_valid_q & cmd_ready_i};
  assign rsp_cnt_d   = rsp_cnt_q + {2'b00, rsp_valid_i};
  assign frame_len_d = (state_q == S_RDATA) ? 3'd4 : 3'd3;
  assign ptr_inc_d   = (int'(slot_q) == NUM_CH - 1) ? 4'd0 : slot_q + 4'd1;
  assign pick_idle_d = find_slot(chan_en_i, ptr_q);
  assign pick_next_d = find_slot(chan_en_i, ptr_inc_d);
  assign drdy_fall_d = drdy_prev_q & ~drdy_s2_q;

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      ptr_q         <= '0;
      mux_q         <= '0;
      byte_cnt_q    <= '0;
      rsp_cnt_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_last_q    <= 1'b0;
      cmd_data_q    <= '0;
      start_q       <= 1'b0;
      start_cnt_q   <= '0;
      wait_q        <= '0;
      data_hi_q     <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_cnt_q <= '0;
      drdy_s1_q     <= 1'b1;
      drdy_s2_q     <= 1'b1;
      drdy_prev_q   <= 1'b0;
    end else begin
      drdy_s1_q   <= drdy_n_i;
      drdy_s2_q   <= drdy_s1_q;
      drdy_prev_q <= drdy_s2_q;

      // Byte streaming shared by WREG and RDATA: next byte follows acceptance.
      if (cmd_valid_q && cmd_ready_i) begin
        byte_cnt_q <= byte_cnt_d;
        if (byte_cnt_d == frame_len_d) begin
          cmd_valid_q <= 1'b0;
          cmd_last_q  <= 1'b0;
        end else begin
          cmd_data_q <= (state_q == S_RDATA) ? rdata_byte(byte_cnt_d)
                                             : wreg_byte(byte_cnt_d, mux_q);
          cmd_last_q <= (byte_cnt_d == frame_len_d - 3'd1);
        end
      end
      if (rsp_valid_i) rsp_cnt_q <= rsp_cnt_d;

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (enable_i && pick_idle_d[4]) begin
            slot_q      <= pick_idle_d[3:0];
            mux_q       <= chan_mux_i[8*pick_idle_d[3:0] +: 8];
            byte_cnt_q  <= '0;
            rsp_cnt_q   <= '0;
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= 8'h40;
            cmd_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_WREG;
          end
        end

        S_WREG: begin
          // All three WREG responses back means the frame is finished.
          if (rsp_valid_i && rsp_cnt_d == 3'd3) begin
            start_q     <= 1'b1;
            start_cnt_q <= SW'(START_W - 1);
            drdy_prev_q <= 1'b0;
            state_q     <= S_START_P;
          end
        end

        S_START_P: begin
          if (start_cnt_q == '0) begin
            start_q <= 1'b0;
            wait_q  <= TW'(TIMEOUT - 1);
            state_q <= S_WAIT_DRDY;
          end else begin
            start_cnt_q <= start_cnt_q - 1'b1;
          end
        end

        S_WAIT_DRDY: begin
          if (drdy_fall_d) begin
            byte_cnt_q  <= '0;
            rsp_cnt_q   <= '0;
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= 8'h12;
            cmd_last_q  <= 1'b0;
            data_hi_q   <= '0;
            state_q     <= S_RDATA;
          end else if (wait_q == '0) begin
            tdata_q  <= {slot_q, 1'b1, 3'b000, 24'h000000};
            tvalid_q <= 1'b1;
            if (timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
            state_q  <= S_OUT;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end

        S_RDATA: begin
          // Response 0 answers the RDATA opcode and is dropped.
          if (rsp_valid_i) begin
            case (rsp_cnt_q)
              3'd1: data_hi_q[15:8] <= rsp_data_i;
              3'd2: data_hi_q[7:0]  <= rsp_data_i;
              3'd3: begin
                tdata_q  <= {slot_q, 4'b0000, data_hi_q, rsp_data_i};
                tvalid_q <= 1'b1;
                state_q  <= S_OUT;
              end
              default: ;
            endcase
          end
        end

        S_OUT: begin
          if (m_axis_tready_i) begin
            tvalid_q <= 1'b0;
            ptr_q    <= ptr_inc_d;
            if (enable_i && pick_next_d[4]) begin
              slot_q      <= pick_next_d[3:0];
              mux_q       <= chan_mux_i[8*pick_next_d[3:0] +: 8];
              byte_cnt_q  <= '0;
              rsp_cnt_q   <= '0;
              cmd_valid_q <= 1'b1;
              cmd_data_q  <= 8'h40;
              cmd_last_q  <= 1'b0;
              state_q     <= S_WREG;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_data_o      = cmd_data_q;
  assign cmd_last_o      = cmd_last_q;
  assign cmd_valid_o     = cmd_valid_q;
  assign start_o         = start_q;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign busy_o          = busy_q;
  assign timeout_cnt_o   = timeout_cnt_q;

endmodule
